// File: rtl/alt_vipvfr121_cpd_pkg.sv
// Shared constants, field widths and FSM state type for the VFR control packet decoder.
// Pure declarations; no logic, latency or flow control.
package alt_vipvfr121_cpd_pkg;

  localparam logic [3:0] CTRL_TYPE  = 4'hF;
  localparam logic [3:0] VIDEO_TYPE = 4'h0;

  localparam int CTRL_NIBBLES = 9;
  localparam int WIDTH_W      = 16;
  localparam int HEIGHT_W     = 16;
  localparam int ILACE_W      = 4;
  localparam int SHADOW_W     = 4 * CTRL_NIBBLES;

  typedef enum logic [1:0] {
    WAIT_SOP,
    CTRL_BODY,
    PASS
  } cpd_state_e;

endpackage

// File: rtl/alt_vipvfr121_cpd_out_reg.sv
// Single-stage registered Avalon-ST source; 1-cycle latency.
// Backpressure: load_rdy = dout_ready || !dout_valid, so a held beat blocks new loads.
module alt_vipvfr121_cpd_out_reg #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_vld,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  load_sop,
  input  logic                  load_eop,
  output logic                  load_rdy,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop
);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;

  assign load_rdy = dout_ready || !vld_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sop_d = sop_q;
    eop_d = eop_q;
    if (load_vld) begin
      vld_d = 1'b1;
      dat_d = load_dat;
      sop_d = load_sop;
      eop_d = load_eop;
    end else if (dout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
    end
  end

  assign dout_valid = vld_q;
  assign dout_data  = dat_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;

endmodule

// File: rtl/alt_vipvfr121_vfr_control_packet_decoder.sv
// Decodes Avalon-ST Video control packets into width/height/interlaced; forwards other packets with 1-cycle latency.
// Input stalls whenever the output stage is full; ALT_VIPVFR121_CPD_FORWARD_CTRL_EN also forwards control packets.
module alt_vipvfr121_vfr_control_packet_decoder
  import alt_vipvfr121_cpd_pkg::*;
#(
  parameter  int BITS_PER_SYMBOL  = 8,
  parameter  int SYMBOLS_PER_BEAT = 3,
  localparam int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  din_ready,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  output logic [WIDTH_W-1:0]    width,
  output logic [HEIGHT_W-1:0]   height,
  output logic [ILACE_W-1:0]    interlaced,
  output logic                  ctrl_update,
  output logic                  ctrl_error,
  output logic                  in_video
);

`ifdef ALT_VIPVFR121_CPD_FORWARD_CTRL_EN
  localparam logic FWD_CTRL = 1'b1;
`else
  localparam logic FWD_CTRL = 1'b0;
`endif

  cpd_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d, merged, commit_src;
  logic [WIDTH_W-1:0]    width_q, width_d;
  logic [HEIGHT_W-1:0]   height_q, height_d;
  logic [ILACE_W-1:0]    ilace_q, ilace_d;
  logic                  upd_q, upd_d, err_q, err_d, in_video_q, in_video_d;
  logic                  accept, fwd_vld, load_rdy, commit;
  logic [4:0]            cnt_sum;
  logic [3:0]            cnt_sat, hdr_type;

  assign din_ready = load_rdy;
  assign accept    = din_valid && load_rdy;
  assign hdr_type  = din_data[3:0];
  assign cnt_sum   = {1'b0, cnt_q} + 5'(SYMBOLS_PER_BEAT);
  assign cnt_sat   = (cnt_sum >= 5'(CTRL_NIBBLES)) ? 4'(CTRL_NIBBLES) : cnt_sum[3:0];

  // Nibble k lands at shadow[(8-k)*4 +: 4], so width/height/interlaced read out MSB-first.
  always_comb begin
    merged = shadow_q;
    for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
      for (int j = 0; j < CTRL_NIBBLES; j++) begin
        if ({1'b0, cnt_q} + 5'(i) == 5'(j)) begin
          merged[(CTRL_NIBBLES-1-j)*4 +: 4] = din_data[i*BITS_PER_SYMBOL +: 4];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    in_video_d = in_video_q;
    fwd_vld    = 1'b0;
    commit     = 1'b0;
    commit_src = shadow_q;
    err_d      = 1'b0;
    if (accept) begin
      if (din_sop) begin
        // A new header closes whatever was open; a fully-filled shadow still commits first.
        if (state_q == CTRL_BODY) begin
          if (cnt_q >= 4'(CTRL_NIBBLES)) commit = 1'b1;
          else                           err_d  = 1'b1;
        end
        in_video_d = 1'b0;
        if (hdr_type == CTRL_TYPE) begin
          fwd_vld  = FWD_CTRL;
          cnt_d    = '0;
          shadow_d = '0;
          if (din_eop) begin
            err_d   = 1'b1;
            state_d = WAIT_SOP;
          end else begin
            state_d = CTRL_BODY;
          end
        end else begin
          fwd_vld    = 1'b1;
          in_video_d = (hdr_type == VIDEO_TYPE) && !din_eop;
          state_d    = din_eop ? WAIT_SOP : PASS;
        end
      end else begin
        case (state_q)
          CTRL_BODY: begin
            fwd_vld  = FWD_CTRL;
            shadow_d = merged;
            cnt_d    = cnt_sat;
            if (din_eop) begin
              state_d = WAIT_SOP;
              if (cnt_sat >= 4'(CTRL_NIBBLES)) begin
                commit     = 1'b1;
                commit_src = merged;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          PASS: begin
            fwd_vld = 1'b1;
            if (din_eop) begin
              state_d    = WAIT_SOP;
              in_video_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    upd_d    = commit;
    width_d  = commit ? commit_src[SHADOW_W-1 -: WIDTH_W]           : width_q;
    height_d = commit ? commit_src[SHADOW_W-WIDTH_W-1 -: HEIGHT_W]  : height_q;
    ilace_d  = commit ? commit_src[ILACE_W-1:0]                     : ilace_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_SOP;
      cnt_q      <= '0;
      shadow_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      ilace_q    <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      in_video_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      width_q    <= width_d;
      height_q   <= height_d;
      ilace_q    <= ilace_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      in_video_q <= in_video_d;
    end
  end

  assign width       = width_q;
  assign height      = height_q;
  assign interlaced  = ilace_q;
  assign ctrl_update = upd_q;
  assign ctrl_error  = err_q;
  assign in_video    = in_video_q;

  alt_vipvfr121_cpd_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_vld   (fwd_vld),
    .load_dat   (din_data),
    .load_sop   (din_sop),
    .load_eop   (din_eop),
    .load_rdy   (load_rdy),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_sop   (dout_sop),
    .dout_eop   (dout_eop)
  );

endmodule

// File: doc/alt_vipvfr121_vfr_control_packet_decoder.md
Name: alt_vipvfr121_vfr_control_packet_decoder

Overview:
- Avalon-ST Video sink-side counterpart of the VFR control packet encoder.
- Parses the incoming packet stream.
- Consumes control packets (type 0xF) and publishes their width, height and interlaced fields as registered outputs.
- Forwards video and user packets unchanged through one registered output stage.
- Sits at the input of frame-writer and processing chains, ahead of any block that needs frame geometry.

Parameters:
- BITS_PER_SYMBOL, 8, bits per colour plane; must be at least 4.
- SYMBOLS_PER_BEAT, 3, symbols in parallel per beat; 1 to 9 supported.
- Derived DATA_WIDTH = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- din_ready  out  1  sink ready (ready latency 0).
- din_valid  in  1  sink valid.
- din_data  in  DATA_WIDTH  sink data; symbol 0 in LSBs.
- din_sop  in  1  start of packet.
- din_eop  in  1  end of packet.
- dout_ready  in  1  source ready.
- dout_valid  out  1  source valid.
- dout_data  out  DATA_WIDTH  source data.
- dout_sop  out  1  start of packet.
- dout_eop  out  1  end of packet.
- width  out  16  last committed control-packet width.
- height  out  16  last committed control-packet height.
- interlaced  out  4  last committed interlaced nibble.
- ctrl_update  out  1  one-cycle pulse when a complete control packet is committed.
- ctrl_error  out  1  one-cycle pulse when a control packet is truncated.
- in_video  out  1  high from an accepted video header until its eop beat is accepted.

Behaviour:
- Reset (rst low, async):
  - All outputs 0; dout_valid 0; state WAIT_SOP.
  - Shadow registers and nibble counter cleared.
  - Reset mid-packet discards all partial state; nothing is committed.
- Handshake:
  - Beat accepted when din_valid && din_ready.
  - din_ready = dout_ready || !dout_valid, in every state; consumed beats also obey this, which keeps the ordering simple.
  - Output register loads on an accepted forwarded beat.
  - dout_valid clears when dout_ready && no new forwarded beat.
  - Forward latency is 1 cycle.
- Header type = din_data[3:0] of the sop beat.
- State WAIT_SOP:
  - Non-sop beats are dropped silently.
  - Sop with type 0xF → CTRL_BODY, nibble counter = 0; header not forwarded.
  - Sop with any other type: beat forwarded; → PASS unless eop is on the same beat.
  - Type 0x0 additionally sets in_video.
- State CTRL_BODY:
  - Each accepted beat supplies symbols 0..SYMBOLS_PER_BEAT-1, bits [3:0] of each, as nibbles k = count..count+SPB-1.
  - Nibble order: k0..3 = width[15:12..3:0], k4..7 = height[15:12..3:0], k8 = interlaced[3:0].
  - Nibbles with k ≥ 9 are ignored. Counter saturates at 9.
  - On eop with count ≥ 9 after the beat: commit shadow to width/height/interlaced in the same edge; ctrl_update pulses the following cycle; → WAIT_SOP.
  - On eop with count < 9: no commit; ctrl_error pulses; → WAIT_SOP.
  - Extra beats after 9 nibbles are consumed until eop.
- State PASS: beats forwarded; on eop → WAIT_SOP and in_video clears after the eop beat is accepted.
- Sop arriving while in CTRL_BODY or PASS:
  - Treated as a new packet header.
  - An incomplete control packet pulses ctrl_error without committing.
  - A forwarded packet is closed without a synthetic eop.
- Simultaneous commit and new header: commit completes first; outputs hold committed values until the next complete control packet.

Optional Feature:
- Macro: ALT_VIPVFR121_CPD_FORWARD_CTRL_EN.
- Defined: control packets are also forwarded unchanged downstream (header and body), while still being decoded and committed as above.
- Undefined: control packets are consumed and never appear on dout.

Decomposition:
- Shared package alt_vipvfr121_cpd_pkg holds:
  - type constants CTRL_TYPE = 4'hF, VIDEO_TYPE = 4'h0;
  - CTRL_NIBBLES = 9;
  - state enum {WAIT_SOP, CTRL_BODY, PASS};
  - field widths 16/16/4.
- One sub-module, alt_vipvfr121_cpd_out_reg: the single-stage registered Avalon-ST source with ready/valid logic, parameterised by DATA_WIDTH.

Test Plan:
- Control packet, SPB=3, nibbles {0,7,8},{0,0,4},{3,8,2} with eop → width=0x0780 (1920), height=0x0438 (1080), interlaced=0x2; ctrl_update single pulse; nothing on dout.
- Video packet header type 0, then 4 beats, eop on last, dout_ready held low for 3 cycles mid-packet → 5 beats out in order, no loss or duplication; in_video high throughout; 1-cycle latency when ready.
- Truncated control packet: eop on second body beat → ctrl_error pulse; width/height unchanged from previous values.
- Control packet with 6 body beats → fields from the first 9 nibbles only; beats 4-6 consumed; single ctrl_update.
- rst asserted low mid-video-packet and mid-control-packet → dout_valid 0 immediately; outputs 0; first post-reset sop decoded correctly.
- With ALT_VIPVFR121_CPD_FORWARD_CTRL_EN defined, same packet as test 1 → 4 beats appear on dout with sop/eop, and fields still commit.
